nibble_serial_adder_ctrl: RTL and testbench

- Sequencer that performs N-bit add (and optional subtract) by time-multiplexing one ripple_carry_4_bit_adder instance, one nibble per clock, LSB nibble first.
- Registers the carry between nibbles and presents the full-width result with a start/busy/done handshake.
- Trades area for latency on wide operands; it is the multi-precision front end for the existing 4-bit adder datapath.

---
 rtl/nsa_pkg.sv | 18 +
 rtl/ripple_carry_4_bit_adder.sv | 24 ++
 rtl/nibble_serial_adder_ctrl.sv | 158 +++++++++++++++
 tb/tb_nibble_serial_adder_ctrl.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/nsa_pkg.sv
// Shared definitions for the nibble-serial adder controller: FSM encoding,
// slice width and the signed-overflow helper.
package nsa_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } nsa_state_t;

    localparam int NIBBLE_W = 4;

    // Two's-complement overflow: like-signed operands yielding an opposite-signed sum
    function automatic logic signed_ovf(input logic a_msb, input logic b_msb, input logic s_msb);
        return (a_msb == b_msb) && (s_msb != a_msb);
    endfunction

endpackage

// File: rtl/ripple_carry_4_bit_adder.sv
// 4-bit ripple-carry adder slice shared by the serial controller.
module ripple_carry_4_bit_adder (
    output logic [3:0] S,
    output logic       C4,
    input  logic [3:0] A,
    input  logic [3:0] B,
    input  logic       C0
);

    logic [4:0] w_c;

    assign w_c[0] = C0;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_fa
            assign S[gi]     = A[gi] ^ B[gi] ^ w_c[gi];
            assign w_c[gi+1] = (A[gi] & B[gi]) | (w_c[gi] & (A[gi] ^ B[gi]));
        end
    endgenerate

    assign C4 = w_c[4];

endmodule

// File: rtl/nibble_serial_adder_ctrl.sv
// Multi-precision add/subtract sequencer time-multiplexing one 4-bit adder, LSB nibble first.
// Optional subtract support is built when NSA_SUB_EN is defined.
module nibble_serial_adder_ctrl
    import nsa_pkg::*;
#(
    parameter int NIBBLES = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        start,
    input  logic [NIBBLES*NIBBLE_W-1:0] a,
    input  logic [NIBBLES*NIBBLE_W-1:0] b,
    input  logic                        sub,
    output logic                        busy,
    output logic                        done,
    output logic [NIBBLES*NIBBLE_W-1:0] s,
    output logic                        cout,
    output logic                        ovf
);

    localparam int W     = NIBBLES * NIBBLE_W;
    localparam int CNT_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NIBBLES - 1);

    nsa_state_t r_state;
    nsa_state_t w_state_nxt;

    logic [W-1:0]     r_a;
    logic [W-1:0]     r_b;
    logic [W-1:0]     r_acc;
    logic [W-1:0]     r_s;
    logic [CNT_W-1:0] r_cnt;
    logic             r_carry;
    logic             r_a_msb;
    logic             r_b_msb;
    logic             r_cout;
    logic             r_ovf;
    logic             r_busy;
    logic             r_done;

    logic [W-1:0]     w_beff;
    logic             w_cin;
    logic [3:0]       w_sum;
    logic             w_c4;
    logic [W+3:0]     w_cat;
    logic [W-1:0]     w_acc_nxt;

`ifdef NSA_SUB_EN
    assign w_beff = sub ? ~b : b;
    assign w_cin  = sub;
`else
    // sub has no effect in add-only builds; it is folded away here
    assign w_beff = b;
    assign w_cin  = 1'b0 & sub;
`endif

    ripple_carry_4_bit_adder u_adder (
        .S  (w_sum),
        .C4 (w_c4),
        .A  (r_a[3:0]),
        .B  (r_b[3:0]),
        .C0 (r_carry)
    );

    // New sum nibble enters at the top so the LSB nibble ends up at the bottom
    assign w_cat     = {w_sum, r_acc};
    assign w_acc_nxt = w_cat[W+3:NIBBLE_W];

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_state_nxt = RUN;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            RUN: begin
                if (r_cnt == LAST_CNT) begin
                    w_state_nxt = DONE;
                end else begin
                    w_state_nxt = RUN;
                end
            end
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Operand capture, nibble datapath and result registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a     <= '0;
            r_b     <= '0;
            r_acc   <= '0;
            r_s     <= '0;
            r_cnt   <= '0;
            r_carry <= 1'b0;
            r_a_msb <= 1'b0;
            r_b_msb <= 1'b0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_busy <= (w_state_nxt != IDLE);
            r_done <= (w_state_nxt == DONE);
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_a     <= a;
                        r_b     <= w_beff;
                        r_carry <= w_cin;
                        r_cnt   <= '0;
                        r_a_msb <= a[W-1];
                        r_b_msb <= w_beff[W-1];
                    end
                end
                RUN: begin
                    r_acc   <= w_acc_nxt;
                    r_a     <= r_a >> NIBBLE_W;
                    r_b     <= r_b >> NIBBLE_W;
                    r_carry <= w_c4;
                    r_cnt   <= r_cnt + CNT_W'(1);
                    if (r_cnt == LAST_CNT) begin
                        r_s    <= w_acc_nxt;
                        r_cout <= w_c4;
                        r_ovf  <= signed_ovf(r_a_msb, r_b_msb, w_sum[3]);
                    end
                end
                DONE: begin
                    r_cnt <= '0;
                end
                default: begin
                    r_cnt <= '0;
                end
            endcase
        end
    end

    assign busy = r_busy;
    assign done = r_done;
    assign s    = r_s;
    assign cout = r_cout;
    assign ovf  = r_ovf;

endmodule

// File: tb/tb_nibble_serial_adder_ctrl.sv
// Directed self-checking bench for nibble_serial_adder_ctrl with NIBBLES=4.
module tb_nibble_serial_adder_ctrl;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [15:0] a;
    logic [15:0] b;
    logic        sub;
    logic        busy;
    logic        done;
    logic [15:0] s;
    logic        cout;
    logic        ovf;

    int checks;
    int errors;

    nibble_serial_adder_ctrl #(.NIBBLES(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .sub   (sub),
        .busy  (busy),
        .done  (done),
        .s     (s),
        .cout  (cout),
        .ovf   (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Caller is at a negedge; drives start for one cycle and waits (bounded) for done.
    task automatic run_op(input logic [15:0] ia, input logic [15:0] ib, input logic isub, output int lat);
        a = ia; b = ib; sub = isub; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat = 1;
        while (done !== 1'b1 && lat < 30) begin
            @(negedge clk);
            lat++;
        end
        if (done !== 1'b1) lat = 0;
    endtask

    task automatic check_result(input string name, input int lat, input logic [15:0] es,
                                input logic ec, input logic eo);
        checks++;
        if (lat !== 5) begin errors++; $display("FAIL %s latency got %0d want 5", name, lat); end
        checks++;
        if (s !== es) begin errors++; $display("FAIL %s s got %h want %h", name, s, es); end
        checks++;
        if (cout !== ec) begin errors++; $display("FAIL %s cout got %b want %b", name, cout, ec); end
        checks++;
        if (ovf !== eo) begin errors++; $display("FAIL %s ovf got %b want %b", name, ovf, eo); end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; a = '0; b = '0; sub = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({busy, done, s, cout, ovf} !== 20'h0) begin
            errors++;
            $display("FAIL reset outputs got busy=%b done=%b s=%h cout=%b ovf=%b want all 0", busy, done, s, cout, ovf);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_add();
        int lat;
        run_op(16'h1234, 16'h4321, 1'b0, lat);
        check_result("add_1234_4321", lat, 16'h5555, 1'b0, 1'b0);
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL busy_in_done got %b want 1", busy); end
        @(negedge clk);
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL done_pulse_width got done=%b busy=%b want 0 0", done, busy);
        end
        checks++;
        if (s !== 16'h5555) begin errors++; $display("FAIL s_hold got %h want 5555", s); end
        @(negedge clk);
        run_op(16'hFFFF, 16'h0001, 1'b0, lat);
        check_result("carry_ripple", lat, 16'h0000, 1'b1, 1'b0);
        @(negedge clk);
    endtask

    task automatic test_overflow();
        int lat;
        run_op(16'h7FFF, 16'h0001, 1'b0, lat);
        check_result("ovf_pos", lat, 16'h8000, 1'b0, 1'b1);
        @(negedge clk);
        run_op(16'h8000, 16'h8000, 1'b0, lat);
        check_result("ovf_neg", lat, 16'h0000, 1'b1, 1'b1);
        @(negedge clk);
    endtask

    task automatic test_start_while_busy();
        int pulses;
        logic [15:0] cap;
        pulses = 0; cap = '0;
        a = 16'h0010; b = 16'h0020; sub = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        a = 16'hFFFF; b = 16'hFFFF; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 12; i++) begin
            if (done === 1'b1) begin pulses++; cap = s; end
            @(negedge clk);
        end
        checks++;
        if (pulses !== 1) begin errors++; $display("FAIL ignored_start pulses got %0d want 1", pulses); end
        checks++;
        if (cap !== 16'h0030) begin errors++; $display("FAIL ignored_start s got %h want 0030", cap); end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL ignored_start idle busy got %b want 0", busy); end
    endtask

    task automatic test_reset_mid_run();
        int lat;
        int pulses;
        pulses = 0;
        a = 16'h1111; b = 16'h2222; sub = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if ({busy, done, s, cout} !== 19'h0) begin
            errors++;
            $display("FAIL mid_reset got busy=%b done=%b s=%h cout=%b want all 0", busy, done, s, cout);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            if (done === 1'b1) pulses++;
            @(negedge clk);
        end
        checks++;
        if (pulses !== 0) begin errors++; $display("FAIL mid_reset spurious done got %0d want 0", pulses); end
        run_op(16'h0003, 16'h0004, 1'b0, lat);
        check_result("after_reset", lat, 16'h0007, 1'b0, 1'b0);
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        int lat;
        run_op(16'h0100, 16'h0200, 1'b0, lat);
        check_result("b2b_first", lat, 16'h0300, 1'b0, 1'b0);
        @(negedge clk);
        run_op(16'hA5A5, 16'h5A5A, 1'b0, lat);
        check_result("b2b_second", lat, 16'hFFFF, 1'b0, 1'b0);
        @(negedge clk);
    endtask

    task automatic test_sub();
        int lat;
`ifdef NSA_SUB_EN
        run_op(16'h0005, 16'h0003, 1'b1, lat);
        check_result("sub_5_3", lat, 16'h0002, 1'b1, 1'b0);
        @(negedge clk);
        run_op(16'h0003, 16'h0005, 1'b1, lat);
        check_result("sub_3_5", lat, 16'hFFFE, 1'b0, 1'b0);
`else
        run_op(16'h0005, 16'h0003, 1'b1, lat);
        check_result("sub_ignored", lat, 16'h0008, 1'b0, 1'b0);
`endif
        @(negedge clk);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_add();
        test_overflow();
        test_start_while_busy();
        test_reset_mid_run();
        test_back_to_back();
        test_sub();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
